// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first.
// A minuend/subtrahend pair is accepted over a ready/valid channel. One
// difference bit is produced per clock. The WIDTH-bit difference and the
// final borrow are then offered on a ready/valid output channel, where
// they are held until the consumer takes them.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] io_in_minuend,
   input  logic [WIDTH-1:0] io_in_subtrahend,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_out_diff,
   output logic             io_out_borrow,
   output logic             io_busy
);

   // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits are enough.
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    count_q, count_d;

   logic             in_fire;
   logic             out_fire;
   logic             diff_bit;
   logic             borrow_next;

   // Handshake qualifiers and the output channel. Outputs are forced to zero
   // unless a finished result is being offered.
   assign io_in_ready   = (state_q == S_IDLE);
   assign io_out_valid  = (state_q == S_DONE);
   assign io_busy       = (state_q != S_IDLE);
   assign io_out_diff   = (state_q == S_DONE) ? diff_sh_q : '0;
   assign io_out_borrow = (state_q == S_DONE) ? borrow_q : 1'b0;

   assign in_fire  = io_in_valid && io_in_ready;
   assign out_fire = io_out_valid && io_out_ready;

   // One full-subtractor stage working on the current LSBs of the operands.
   assign diff_bit    = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
   assign borrow_next = (~a_sh_q[0] & b_sh_q[0]) |
                        (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);

   // Next-state and datapath update. Registers hold their value unless a
   // state below changes it.
   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      diff_sh_d = diff_sh_q;
      borrow_d  = borrow_q;
      count_d   = count_q;
      case (state_q)
         S_IDLE: begin
            if (in_fire) begin
               a_sh_d    = io_in_minuend;
               b_sh_d    = io_in_subtrahend;
               diff_sh_d = '0;
               borrow_d  = 1'b0;
               count_d   = '0;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // Difference bits enter at the MSB, so after WIDTH steps the
            // first (LSB) bit has reached position 0.
            diff_sh_d = {diff_bit, diff_sh_q[WIDTH-1:1]};
            a_sh_d    = a_sh_q >> 1;
            b_sh_d    = b_sh_q >> 1;
            borrow_d  = borrow_next;
            if (count_q == LAST_BIT) begin
               state_d = S_DONE;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         S_DONE: begin
            // The result is held here, unchanged, until the consumer takes it.
            if (out_fire) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers. The reset is asynchronous, so a pending
   // operation is discarded as soon as reset falls.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         diff_sh_q <= '0;
         borrow_q  <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         diff_sh_q <= diff_sh_d;
         borrow_q  <= borrow_d;
         count_q   <= count_d;
      end
   end

`ifndef SYNTHESIS
`ifdef PRINTF_COND
   // Trace support only. The shift registers consume the operands, so the
   // original values are kept here for the message.
   logic [WIDTH-1:0] trace_a_q, trace_a_d;
   logic [WIDTH-1:0] trace_b_q, trace_b_d;

   // Latch the original operands when they are accepted.
   always_comb begin
      trace_a_d = trace_a_q;
      trace_b_d = trace_b_q;
      if (in_fire) begin
         trace_a_d = io_in_minuend;
         trace_b_d = io_in_subtrahend;
      end
   end

   // Register the operand copies.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         trace_a_q <= '0;
         trace_b_q <= '0;
      end else begin
         trace_a_q <= trace_a_d;
         trace_b_q <= trace_b_d;
      end
   end

   // Report each completed result at its output handshake.
   always @(posedge clock) begin
      if (reset && out_fire) begin
         $display("Subtractor: %d := %d - %d (borrow %d)",
                  io_out_diff, trace_a_q, trace_b_q, io_out_borrow);
      end
   end
`endif
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomised stimulus for serial_subtractor.
// A transaction-level model tracks when a result must be offered and what
// it must be. The DUT outputs are compared against it on every falling edge.
module tb_serial_subtractor;

   localparam int W   = 8;
   localparam int W16 = 16;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   // 8-bit DUT signals
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] diff;
   logic         borrow;
   logic         busy;

   // 16-bit DUT signals
   logic           in16_valid = 1'b0;
   logic           in16_ready;
   logic [W16-1:0] a16 = '0;
   logic [W16-1:0] b16 = '0;
   logic           out16_valid;
   logic           out16_ready = 1'b0;
   logic [W16-1:0] diff16;
   logic           borrow16;
   logic           busy16;

   serial_subtractor #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset),
      .io_in_valid(in_valid), .io_in_ready(in_ready),
      .io_in_minuend(a), .io_in_subtrahend(b),
      .io_out_valid(out_valid), .io_out_ready(out_ready),
      .io_out_diff(diff), .io_out_borrow(borrow), .io_busy(busy)
   );

   serial_subtractor #(.WIDTH(W16)) dut16 (
      .clock(clock), .reset(reset),
      .io_in_valid(in16_valid), .io_in_ready(in16_ready),
      .io_in_minuend(a16), .io_in_subtrahend(b16),
      .io_out_valid(out16_valid), .io_out_ready(out16_ready),
      .io_out_diff(diff16), .io_out_borrow(borrow16), .io_busy(busy16)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Transaction model: 0 = waiting for operands, 1 = working (edges since
   // accept), 2 = result offered. A result appears exactly W edges after accept.
   int           m_phase = 0;
   int           m_edges = 0;
   logic [W-1:0] m_a = '0;
   logic [W-1:0] m_b = '0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_phase <= 0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
               m_a     <= a;
               m_b     <= b;
               m_edges <= 0;
               m_phase <= 1;
            end
            1: begin
               m_edges <= m_edges + 1;
               if (m_edges + 1 == W) m_phase <= 2;
            end
            default: if (out_ready) m_phase <= 0;
         endcase
      end
   end

   // Per-cycle compare against the model, plus handshake bookkeeping.
   int   acc_cnt  = 0;
   int   hs_cnt   = 0;
   int   prev_acc = 0;
   logic have_prev = 1'b0;
   logic [W-1:0] exp_diff;
   logic         exp_borrow;

   always @(negedge clock) begin
      if (!reset) begin
         have_prev = 1'b0;
      end else begin
         exp_diff   = (m_phase == 2) ? W'(m_a - m_b) : '0;
         exp_borrow = (m_phase == 2) && (m_a < m_b);
         chk("model_in_ready", 32'(in_ready), 32'(m_phase == 0));
         chk("model_out_valid", 32'(out_valid), 32'(m_phase == 2));
         chk("model_busy", 32'(busy), 32'(m_phase != 0));
         chk("model_diff", 32'(diff), 32'(exp_diff));
         chk("model_borrow", 32'(borrow), 32'(exp_borrow));
         if (in_valid && in_ready) begin
            acc_cnt++;
            if (have_prev) chk("accept_gap_ok", 32'(cyc - prev_acc >= W + 2), 32'd1);
            prev_acc  = cyc;
            have_prev = 1'b1;
         end
         if (out_valid && out_ready) hs_cnt++;
      end
   end

   // Present operands and wait (bounded) for the accepting edge.
   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
      logic r;
      int   n;
      a = av; b = bv; in_valid = 1'b1; n = 0;
      do begin
         r = in_ready;
         @(posedge clock); #1;
         n++;
      end while (!r && n < 100);
      in_valid = 1'b0;
      if (!r) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   // Count edges from accept to out_valid and check the literal result.
   task automatic wait_result(input logic [W-1:0] ed, input logic eb, input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(W));
      chk({tag, "_diff"}, 32'(diff), 32'(ed));
      chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
   endtask

   // Take the result and confirm a return to idle one cycle later.
   task automatic finish_op(input string tag);
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
      $display("txn %s: done at cycle %0d", tag, cyc);
   endtask

   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb, input string tag);
      start_op(av, bv);
      wait_result(ed, eb, tag);
      finish_op(tag);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, want summary");
      $fatal(1, "watchdog");
   end

   int   acc0, hs0, n;
   logic b2b_done;

   initial begin
      // Reset state, observed while reset is held.
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_borrow", 32'(borrow), 32'd0);
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b1;

      // Directed vectors with hand-computed results.
      run_op(8'd200, 8'd55, 8'd145, 1'b0, "v200_55");
      run_op(8'd5, 8'd10, 8'd251, 1'b1, "v5_10");
      run_op(8'd0, 8'd0, 8'd0, 1'b0, "v0_0");
      run_op(8'd255, 8'd255, 8'd0, 1'b0, "v255_255");
      run_op(8'd0, 8'd255, 8'd1, 1'b1, "v0_255");

      // Backpressure: result held for 20 cycles, new operands ignored meanwhile.
      start_op(8'd100, 8'd1);
      wait_result(8'd99, 1'b0, "bp");
      a = 8'd9; b = 8'd9; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_diff", 32'(diff), 32'd99);
         chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      chk("bp_single_hs", 32'(out_valid), 32'd0);
      chk("bp_idle_after", 32'(in_ready), 32'd1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      chk("bp_next_accepted", 32'(busy), 32'd1);
      wait_result(8'd0, 1'b0, "bp_next");
      finish_op("bp_next");

      // Asynchronous reset in the middle of an operation.
      start_op(8'd77, 8'd7);
      repeat (3) begin @(posedge clock); #1; end
      #2 reset = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_diff", 32'(diff), 32'd0);
      @(posedge clock); #3;
      reset = 1'b1;
      repeat (3) begin
         @(posedge clock); #1;
         chk("arst_no_stale_valid", 32'(out_valid), 32'd0);
         chk("arst_ready_after", 32'(in_ready), 32'd1);
      end
      run_op(8'd3, 8'd2, 8'd1, 1'b0, "post_rst");

      // Back-to-back: 16 random pairs, in_valid held high, random out_ready.
      acc0 = acc_cnt; hs0 = hs_cnt; b2b_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               logic r;
               int   k;
               a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1; k = 0;
               do begin
                  r = in_ready;
                  @(posedge clock); #1;
                  k++;
               end while (!r && k < 500);
               if (!r) chk("b2b_accept_timeout", 32'd0, 32'd1);
               $display("txn b2b[%0d]: accepted at cycle %0d", i, cyc);
            end
            in_valid = 1'b0;
            b2b_done = 1'b1;
         end
         begin
            while (!b2b_done) begin
               out_ready = 1'($urandom_range(0, 1));
               @(posedge clock); #1;
            end
         end
      join
      out_ready = 1'b1;
      n = 0;
      while (hs_cnt - hs0 < 16 && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      out_ready = 1'b0;
      chk("b2b_accepts", 32'(acc_cnt - acc0), 32'd16);
      chk("b2b_handshakes", 32'(hs_cnt - hs0), 32'd16);

      // 16-bit instance: 0x0000 - 0x0001.
      begin
         logic r;
         int   k;
         a16 = 16'h0000; b16 = 16'h0001; in16_valid = 1'b1; k = 0;
         do begin
            r = in16_ready;
            @(posedge clock); #1;
            k++;
         end while (!r && k < 100);
         in16_valid = 1'b0;
         if (!r) chk("w16_accept_timeout", 32'd0, 32'd1);
         k = 0;
         while (!out16_valid && k < 100) begin
            @(posedge clock); #1;
            k++;
         end
         chk("w16_latency", 32'(k), 32'd16);
         chk("w16_diff", 32'(diff16), 32'h0000_FFFF);
         chk("w16_borrow", 32'(borrow16), 32'd1);
         out16_ready = 1'b1;
         @(posedge clock); #1;
         out16_ready = 1'b0;
         chk("w16_ready_after", 32'(in16_ready), 32'd1);
         $display("txn w16: done at cycle %0d", cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
